// File: rtl/ps2_kbd_ascii.sv
// PS/2 set-2 keyboard receiver and decoder: synchronises and filters the PS/2 lines,
// frames 11-bit packets, and turns make codes into ASCII/Enter strobes with shift tracking.
module ps2_kbd_ascii #(
  parameter int FILT_LEN    = 4,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] ASCII,
  output logic       ASCII_EN,
  output logic       K_ENTER,
  output logic       SHIFT,
  output logic       ERR
);

  localparam int FW = $clog2(FILT_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } rx_state_e;

  logic [1:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic          filt_clk;
  logic          filt_clk_d;
  logic [FW-1:0] filt_cnt;
  logic          fe;
  logic          dat;

  rx_state_e     state;
  rx_state_e     state_next;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] to_cnt;
  logic          timeout;
  logic          byte_ok;
  logic          frame_err;

  logic          brk;
  logic          ext;
  logic [8:0]    mapped;

  // Idle PS/2 lines are high, so the synchronisers and filter reset to 1 to avoid a false edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      clk_sync   <= 2'b11;
      dat_sync   <= 2'b11;
      filt_clk   <= 1'b1;
      filt_clk_d <= 1'b1;
      filt_cnt   <= '0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample pre-edge values, which is what
      // makes the two-stage synchroniser a real two-stage shift rather than a single wire.
      clk_sync   <= {clk_sync[0], PS2_CLK};
      dat_sync   <= {dat_sync[0], PS2_DAT};
      filt_clk_d <= filt_clk;
      if (clk_sync[1] != filt_clk) begin
        if (filt_cnt == FW'(FILT_LEN - 1)) begin
          filt_clk <= clk_sync[1];
          filt_cnt <= '0;
        end else begin
          filt_cnt <= filt_cnt + 1'b1;
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  assign fe      = filt_clk_d & ~filt_clk;
  assign dat     = dat_sync[1];
  assign timeout = (state != S_IDLE) && (to_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned
    // and no latch is inferred.
    state_next = state;
    byte_ok    = 1'b0;
    frame_err  = 1'b0;
    if (timeout) begin
      state_next = S_IDLE;
    end else if (fe) begin
      case (state)
        S_IDLE:   if (!dat) state_next = S_DATA;
        S_DATA:   if (bit_cnt == 3'd7) state_next = S_PARITY;
        S_PARITY: state_next = S_STOP;
        S_STOP: begin
          state_next = S_IDLE;
          if (dat && (^{shreg, par_bit})) byte_ok   = 1'b1;
          else                            frame_err = 1'b1;
        end
        default:  state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      to_cnt  <= '0;
    end else begin
      if (state == S_IDLE || fe) to_cnt <= '0;
      else                       to_cnt <= to_cnt + 1'b1;
      if (fe) begin
        case (state)
          S_IDLE:   bit_cnt <= '0;
          S_DATA: begin
            shreg   <= {dat, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          S_PARITY: par_bit <= dat;
          default:  ;
        endcase
      end
    end
  end

  // Returns {hit, ascii} for the un-extended printable keys; letters are always uppercase.
  function automatic logic [8:0] key_map(input logic [7:0] code);
    case (code)
      8'h1C: key_map = {1'b1, 8'h41};  8'h32: key_map = {1'b1, 8'h42};
      8'h21: key_map = {1'b1, 8'h43};  8'h23: key_map = {1'b1, 8'h44};
      8'h24: key_map = {1'b1, 8'h45};  8'h2B: key_map = {1'b1, 8'h46};
      8'h34: key_map = {1'b1, 8'h47};  8'h33: key_map = {1'b1, 8'h48};
      8'h43: key_map = {1'b1, 8'h49};  8'h3B: key_map = {1'b1, 8'h4A};
      8'h42: key_map = {1'b1, 8'h4B};  8'h4B: key_map = {1'b1, 8'h4C};
      8'h3A: key_map = {1'b1, 8'h4D};  8'h31: key_map = {1'b1, 8'h4E};
      8'h44: key_map = {1'b1, 8'h4F};  8'h4D: key_map = {1'b1, 8'h50};
      8'h15: key_map = {1'b1, 8'h51};  8'h2D: key_map = {1'b1, 8'h52};
      8'h1B: key_map = {1'b1, 8'h53};  8'h2C: key_map = {1'b1, 8'h54};
      8'h3C: key_map = {1'b1, 8'h55};  8'h2A: key_map = {1'b1, 8'h56};
      8'h1D: key_map = {1'b1, 8'h57};  8'h22: key_map = {1'b1, 8'h58};
      8'h35: key_map = {1'b1, 8'h59};  8'h1A: key_map = {1'b1, 8'h5A};
      8'h45: key_map = {1'b1, 8'h30};  8'h16: key_map = {1'b1, 8'h31};
      8'h1E: key_map = {1'b1, 8'h32};  8'h26: key_map = {1'b1, 8'h33};
      8'h25: key_map = {1'b1, 8'h34};  8'h2E: key_map = {1'b1, 8'h35};
      8'h36: key_map = {1'b1, 8'h36};  8'h3D: key_map = {1'b1, 8'h37};
      8'h3E: key_map = {1'b1, 8'h38};  8'h46: key_map = {1'b1, 8'h39};
      8'h29: key_map = {1'b1, 8'h20};  8'h66: key_map = {1'b1, 8'h08};
      default: key_map = 9'h000;
    endcase
  endfunction

  assign mapped = key_map(shreg);

  // Decode runs on the cycle the stop bit validates, so strobes appear one CLK after that edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ASCII    <= '0;
      ASCII_EN <= 1'b0;
      K_ENTER  <= 1'b0;
      SHIFT    <= 1'b0;
      ERR      <= 1'b0;
      brk      <= 1'b0;
      ext      <= 1'b0;
    end else begin
      ASCII_EN <= 1'b0;
      K_ENTER  <= 1'b0;
      ERR      <= frame_err | timeout;
      if (frame_err || timeout) begin
        brk <= 1'b0;
        ext <= 1'b0;
      end else if (byte_ok) begin
        if (shreg == 8'hF0) begin
          brk <= 1'b1;
        end else if (shreg == 8'hE0) begin
          ext <= 1'b1;
        end else begin
          brk <= 1'b0;
          ext <= 1'b0;
          if (brk) begin
            if (!ext && (shreg == 8'h12 || shreg == 8'h59)) SHIFT <= 1'b0;
          end else if (!ext && (shreg == 8'h12 || shreg == 8'h59)) begin
            SHIFT <= 1'b1;
          end else if (shreg == 8'h5A) begin
            K_ENTER <= 1'b1;
          end else if (!ext && mapped[8]) begin
            ASCII    <= mapped[7:0];
            ASCII_EN <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_kbd_ascii.sv
// Self-checking bench for ps2_kbd_ascii: directed vector table, multi-cycle corner cases
// (reset mid-frame, glitch, timeout) and a randomised key stream against a lookup-table model.
module tb_ps2_kbd_ascii;

  localparam int HALF = 12;
  localparam int TO   = 300;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       PS2_CLK = 1'b1;
  logic       PS2_DAT = 1'b1;
  logic [7:0] ASCII;
  logic       ASCII_EN;
  logic       K_ENTER;
  logic       SHIFT;
  logic       ERR;

  always #5 CLK = ~CLK;

  ps2_kbd_ascii #(.FILT_LEN(4), .TIMEOUT_CYC(TO)) dut (
    .CLK(CLK), .RST_N(RST_N), .PS2_CLK(PS2_CLK), .PS2_DAT(PS2_DAT),
    .ASCII(ASCII), .ASCII_EN(ASCII_EN), .K_ENTER(K_ENTER), .SHIFT(SHIFT), .ERR(ERR)
  );

  int total = 0;
  int bad = 0;
  int n_en = 0, n_ent = 0, n_err = 0, n_both = 0;

  always @(negedge CLK) begin
    if (ASCII_EN) n_en++;
    if (K_ENTER) n_ent++;
    if (ERR) n_err++;
    if (ASCII_EN && K_ENTER) n_both++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Reference model: character lookup built from the key tables, plus prefix/shift state.
  logic [7:0] amap [logic [7:0]];
  logic [7:0] key_codes[$];
  bit         m_brk, m_ext, m_shift;
  logic [7:0] m_ascii;

  task automatic model_reset();
    m_brk = 0; m_ext = 0; m_shift = 0; m_ascii = 8'h00;
  endtask

  task automatic model_step(input logic [7:0] c, input bit is_err,
                            output int en, output int ent, output int er);
    bit is_shift;
    en = 0; ent = 0; er = 0;
    is_shift = (c == 8'h12) || (c == 8'h59);
    if (is_err) begin
      er = 1; m_brk = 0; m_ext = 0;
    end else if (c == 8'hF0) begin
      m_brk = 1;
    end else if (c == 8'hE0) begin
      m_ext = 1;
    end else begin
      if (m_brk) begin
        if (!m_ext && is_shift) m_shift = 0;
      end else if (!m_ext && is_shift) begin
        m_shift = 1;
      end else if (c == 8'h5A) begin
        ent = 1;
      end else if (!m_ext && amap.exists(c)) begin
        m_ascii = amap[c];
        en = 1;
      end
      m_brk = 0; m_ext = 0;
    end
  endtask

  function automatic logic [10:0] frame(input logic [7:0] c, input bit bp, input bit bs);
    logic p;
    p = ~(^c) ^ bp;
    return {~bs, p, c, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      PS2_DAT = b[i];
      wait_cyc(HALF);
      PS2_CLK = 1'b0;
      wait_cyc(HALF);
      PS2_CLK = 1'b1;
    end
  endtask

  // Sends one full frame (fault 1 = bad parity, 2 = bad stop) and reports DUT strobe counts
  // alongside the model's expectation for the same byte.
  task automatic xfer(input logic [7:0] c, input int fault,
                      output int den, output int dent, output int derr,
                      output int men, output int ment, output int merr);
    int e0, t0, r0;
    e0 = n_en; t0 = n_ent; r0 = n_err;
    send_bits(frame(c, fault == 1, fault == 2), 11);
    wait_cyc(HALF);
    PS2_DAT = 1'b1;
    wait_cyc(4);
    den = n_en - e0; dent = n_ent - t0; derr = n_err - r0;
    model_step(c, fault != 0, men, ment, merr);
  endtask

  typedef struct {
    logic [7:0] code;
    int         fault;
    int         n_en;
    logic [7:0] ascii;
    int         n_ent;
    logic       shift;
    int         n_err;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] c, input int f, input int en,
                              input logic [7:0] a, input int ent, input logic sh, input int er);
    vec_t v;
    v.code = c; v.fault = f; v.n_en = en; v.ascii = a; v.n_ent = ent; v.shift = sh; v.n_err = er;
    return v;
  endfunction

  initial begin
    string      letters;
    logic [7:0] lc[26];
    logic [7:0] dc[10];
    vec_t       vecs[$];
    int         den, dent, derr, men, ment, merr, e0, r0;
    logic [7:0] rc;
    int         sel;

    letters = "ABCDEFGHIJKLMNOPQRSTUVWXYZ";
    lc = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B,
           8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
           8'h35, 8'h1A};
    dc = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    for (int i = 0; i < 26; i++) begin amap[lc[i]] = letters[i]; key_codes.push_back(lc[i]); end
    for (int i = 0; i < 10; i++) begin amap[dc[i]] = 8'h30 + 8'(i); key_codes.push_back(dc[i]); end
    amap[8'h29] = 8'h20; key_codes.push_back(8'h29);
    amap[8'h66] = 8'h08; key_codes.push_back(8'h66);
    model_reset();

    // Power-on reset values
    wait_cyc(5);
    check("rst ascii", ASCII, 0);
    check("rst ascii_en", ASCII_EN, 0);
    check("rst k_enter", K_ENTER, 0);
    check("rst shift", SHIFT, 0);
    check("rst err", ERR, 0);
    RST_N = 1'b1;
    wait_cyc(5);

    // Reset in the middle of a frame clears shift state and receiver
    xfer(8'h12, 0, den, dent, derr, men, ment, merr);
    check("t1 shift set", SHIFT, 1);
    send_bits(frame(8'h1C, 0, 0), 5);
    wait_cyc(HALF);
    RST_N = 1'b0;
    wait_cyc(3);
    check("t1 rst shift", SHIFT, 0);
    check("t1 rst ascii", ASCII, 0);
    RST_N = 1'b1;
    PS2_DAT = 1'b1;
    model_reset();
    wait_cyc(50);
    xfer(8'h1C, 0, den, dent, derr, men, ment, merr);
    check("t1 en", den, 1);
    check("t1 ascii", ASCII, 8'h41);
    check("t1 err", derr, 0);

    vecs.push_back(mk(8'h1C, 0, 1, 8'h41, 0, 0, 0));
    vecs.push_back(mk(8'hF0, 0, 0, 8'h41, 0, 0, 0));
    vecs.push_back(mk(8'h1C, 0, 0, 8'h41, 0, 0, 0));
    vecs.push_back(mk(8'h32, 0, 1, 8'h42, 0, 0, 0));
    vecs.push_back(mk(8'hF0, 0, 0, 8'h42, 0, 0, 0));
    vecs.push_back(mk(8'h32, 0, 0, 8'h42, 0, 0, 0));
    vecs.push_back(mk(8'h5A, 0, 0, 8'h42, 1, 0, 0));
    vecs.push_back(mk(8'hE0, 0, 0, 8'h42, 0, 0, 0));
    vecs.push_back(mk(8'h5A, 0, 0, 8'h42, 1, 0, 0));
    vecs.push_back(mk(8'hE0, 0, 0, 8'h42, 0, 0, 0));
    vecs.push_back(mk(8'hF0, 0, 0, 8'h42, 0, 0, 0));
    vecs.push_back(mk(8'h5A, 0, 0, 8'h42, 0, 0, 0));
    vecs.push_back(mk(8'h12, 0, 0, 8'h42, 0, 1, 0));
    vecs.push_back(mk(8'h16, 0, 1, 8'h31, 0, 1, 0));
    vecs.push_back(mk(8'hF0, 0, 0, 8'h31, 0, 1, 0));
    vecs.push_back(mk(8'h12, 0, 0, 8'h31, 0, 0, 0));
    vecs.push_back(mk(8'h59, 0, 1 - 1, 8'h31, 0, 1, 0));
    vecs.push_back(mk(8'hE0, 0, 0, 8'h31, 0, 1, 0));
    vecs.push_back(mk(8'h12, 0, 0, 8'h31, 0, 1, 0));
    vecs.push_back(mk(8'hF0, 0, 0, 8'h31, 0, 1, 0));
    vecs.push_back(mk(8'h59, 0, 0, 8'h31, 0, 0, 0));
    vecs.push_back(mk(8'h21, 1, 0, 8'h31, 0, 0, 1));
    vecs.push_back(mk(8'h21, 2, 0, 8'h31, 0, 0, 1));
    vecs.push_back(mk(8'h21, 0, 1, 8'h43, 0, 0, 0));
    vecs.push_back(mk(8'hF0, 1, 0, 8'h43, 0, 0, 1));
    vecs.push_back(mk(8'h29, 0, 1, 8'h20, 0, 0, 0));
    vecs.push_back(mk(8'h66, 0, 1, 8'h08, 0, 0, 0));
    vecs.push_back(mk(8'h45, 0, 1, 8'h30, 0, 0, 0));
    vecs.push_back(mk(8'h0E, 0, 0, 8'h30, 0, 0, 0));
    vecs.push_back(mk(8'hE0, 0, 0, 8'h30, 0, 0, 0));
    vecs.push_back(mk(8'h1C, 0, 0, 8'h30, 0, 0, 0));
    vecs.push_back(mk(8'h1A, 0, 1, 8'h5A, 0, 0, 0));
    vecs.push_back(mk(8'h46, 0, 1, 8'h39, 0, 0, 0));
    vecs.push_back(mk(8'h46, 0, 1, 8'h39, 0, 0, 0));

    foreach (vecs[i]) begin
      xfer(vecs[i].code, vecs[i].fault, den, dent, derr, men, ment, merr);
      check($sformatf("v%0d en", i), den, vecs[i].n_en);
      check($sformatf("v%0d ascii", i), ASCII, vecs[i].ascii);
      check($sformatf("v%0d enter", i), dent, vecs[i].n_ent);
      check($sformatf("v%0d shift", i), SHIFT, vecs[i].shift);
      check($sformatf("v%0d err", i), derr, vecs[i].n_err);
    end

    // Clock glitch shorter than the filter while data is low must not start a frame
    PS2_DAT = 1'b0;
    wait_cyc(4);
    PS2_CLK = 1'b0;
    wait_cyc(3);
    PS2_CLK = 1'b1;
    wait_cyc(10);
    PS2_DAT = 1'b1;
    wait_cyc(20);
    xfer(8'h1C, 0, den, dent, derr, men, ment, merr);
    check("glitch en", den, 1);
    check("glitch ascii", ASCII, 8'h41);
    check("glitch err", derr, 0);

    // Break prefix followed by an abandoned frame: timeout error drops the prefix
    xfer(8'hF0, 0, den, dent, derr, men, ment, merr);
    e0 = n_en; r0 = n_err;
    send_bits(frame(8'h21, 0, 0), 4);
    PS2_DAT = 1'b1;
    wait_cyc(TO + 200);
    check("t6 err", n_err - r0, 1);
    check("t6 no en", n_en - e0, 0);
    model_step(8'h00, 1, men, ment, merr);
    xfer(8'h21, 0, den, dent, derr, men, ment, merr);
    check("t6 en", den, 1);
    check("t6 ascii", ASCII, 8'h43);

    // Random key stream against the model
    for (int i = 0; i < 60; i++) begin
      int f;
      f = 0;
      sel = int'($urandom_range(0, 9));
      case (sel)
        0, 1, 2, 3: rc = key_codes[$urandom_range(0, key_codes.size() - 1)];
        4:          rc = 8'hF0;
        5:          rc = 8'hE0;
        6:          rc = ($urandom_range(0, 1) == 0) ? 8'h12 : 8'h59;
        7:          rc = 8'h5A;
        8:          rc = ($urandom_range(0, 1) == 0) ? 8'h0E : 8'h76;
        default: begin rc = key_codes[$urandom_range(0, key_codes.size() - 1)]; f = 1; end
      endcase
      xfer(rc, f, den, dent, derr, men, ment, merr);
      check($sformatf("r%0d %0h en", i, rc), den, men);
      check($sformatf("r%0d %0h enter", i, rc), dent, ment);
      check($sformatf("r%0d %0h err", i, rc), derr, merr);
      check($sformatf("r%0d %0h shift", i, rc), SHIFT, m_shift);
      check($sformatf("r%0d %0h ascii", i, rc), ASCII, m_ascii);
    end

    check("en and enter never together", n_both, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
